time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Button-driven time/alarm entry controller that drives the load side of the alarm clock: it produces the H_in1/H_in0/M_in1/M_in0 digit bus and the LD_time/LD_alarm strobes that the clock consumes. It runs on the same 10 Hz `clk` and debounces three push-buttons. It walks an edit state machine over the four digits, enforcing valid 00:00–23:59 values. It then holds the selected load strobe long enough to be captured by the clock's 1-second domain.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2, consecutive high samples required to register a button press (1..15).
- LOAD_CYCLES, 10, cycles the load strobe is held. Must be ≥ the clock's 1 s divider period of 10 clk cycles.
- TIMEOUT_CYCLES, 300, idle cycles in an edit state before abort (30 s at 10 Hz; 9-bit counter).

Ports:
- clk  in  1  10 Hz system clock, the same clock feeding the alarm clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw button, asynchronous: enter edit / abort edit.
- btn_next  in  1  raw button: advance to next digit / commit after last digit.
- btn_inc  in  1  raw button: increment the current digit.
- sel_alarm  in  1  level, sampled on edit entry: 1 = edit alarm, 0 = edit time.
- cur_H1 / cur_H0 / cur_M1 / cur_M0  in  2/4/4/4  current clock digits, used as preload for time edits.
- H_in1  out  2  hour tens digit to clock.
- H_in0  out  4  hour units digit.
- M_in1  out  4  minute tens digit.
- M_in0  out  4  minute units digit.
- LD_time  out  1  time load strobe.
- LD_alarm  out  1  alarm load strobe.
- editing  out  1  high in any EDIT state (display blink enable).
- edit_digit  out  2  digit under edit: 0=H1, 1=H0, 2=M1, 3=M0; 0 outside edit.

## Operation
- Button path: 2-flop synchronizer, then a per-button stable counter.
  - A press event fires once when the synchronized level has been high for DEBOUNCE_CYCLES consecutive samples.
  - No further event fires until the level has been low for DEBOUNCE_CYCLES samples. No auto-repeat.
- States: IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, COMMIT.
- IDLE + mode event → EDIT_H1.
  - Latch target = sel_alarm.
  - Preload the digit registers: cur_* when target=time; 0,0,0,0 when target=alarm.
- EDIT_x + inc event → increment the current digit with wrap. Limits:
  - H1: 0..2.
  - H0: 0..9, or 0..3 when H1=2.
  - M1: 0..5.
  - M0: 0..9.
- Incrementing H1 to 2 while H0>3 clamps H0 to 3 on the same edge.
- A preloaded out-of-range digit (for example cur_H1=2 with cur_H0>3) is clamped on edit entry.
- Digit transitions on a next event:
  - EDIT_H1→EDIT_H0→EDIT_M1→EDIT_M0.
  - EDIT_M0 + next → COMMIT.
- EDIT_x + mode event → IDLE: no strobe, digit outputs retain their values.
- Timeout: any EDIT state with no press event for TIMEOUT_CYCLES cycles → IDLE, no strobe. Every press event restarts the counter.
- COMMIT: assert LD_time (target=time) or LD_alarm (target=alarm) for exactly LOAD_CYCLES cycles, then → IDLE.
  - Only one strobe is ever high at a time.
  - All button events are discarded during COMMIT.
- Same-cycle events: mode > next > inc. Only the highest-priority event acts; the others are dropped.
- Digit outputs are registers. They are stable throughout COMMIT and hold their value afterwards.

## Timing
- Reset (reset_n low, async): state=IDLE; H_in1=0, H_in0=0, M_in1=0, M_in0=0; LD_time=0, LD_alarm=0; editing=0, edit_digit=0; debounce and timeout counters cleared.
- Reset asserted mid-COMMIT drops the strobe immediately (asynchronously).
- Press latency: a raw button rising before edge 0 and held produces its registered effect at edge 2+DEBOUNCE_CYCLES (edge 4 with defaults).
- COMMIT timing:
  - Strobe rises on the edge that enters COMMIT.
  - It stays high for LOAD_CYCLES edges.
  - It falls on the edge returning to IDLE.
  - A new edit can start on the next event.
- editing and edit_digit are registered and change on the same edge as the state.
- The timeout abort occurs on the TIMEOUT_CYCLES-th idle edge after the last event.

## Test plan
- Reset values: reset_n low mid-run → all outputs 0 asynchronously, state IDLE. Release, then press inc → no change.
- Full time edit:
  - Stimulus: cur=12:34, sel_alarm=0; press mode, then next×4.
  - Required: LD_time high exactly 10 cycles with H_in=1,2 and M_in=3,4; LD_alarm stays 0.
- Hour clamp and wrap:
  - Alarm edit, preload 00:00.
  - inc ×2 on H1 → 2. next, inc ×5 on H0 → sequence 1,2,3,0,1.
  - Then, in a separate run starting from H0=7, inc H1 to 2 → H0 clamps to 3.
  - Commit → LD_alarm with 21:00.
- Wraps:
  - M1 from 5 + inc → 0.
  - M0 from 9 + inc → 0.
  - H1 from 2 + inc → 0, with H0 keeping its value.
- Debounce and priority:
  - A 1-cycle glitch on btn_inc → no event.
  - Held btn_inc for 50 cycles → exactly one increment.
  - mode and next events in the same cycle during EDIT_H0 → abort to IDLE, no strobe.
- Abort paths:
  - No press for 300 cycles in EDIT_M1 → IDLE, editing=0, no strobe.
  - Presses during COMMIT → ignored; strobe width stays 10.

Source files
------------

// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - digit bus and load strobes from the entry controller to the clock
interface time_set_ctrl_if;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       editing;
    logic [1:0] edit_digit;

    modport master (
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm,
        output editing, edit_digit
    );

    modport slave (
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm,
        input  editing, edit_digit
    );
endinterface

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - debounced three-button editor that loads time/alarm digits into the clock
module time_set_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);
    localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic       latched;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            latched <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            // Released: count consecutive highs to fire. Latched: count consecutive lows to re-arm.
            if (sync2 == latched) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt     <= '0;
                latched <= sync2;
                press   <= sync2;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int LOAD_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES  = 300
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   btn_mode,
    input  logic                   btn_next,
    input  logic                   btn_inc,
    input  logic                   sel_alarm,
    input  logic [1:0]             cur_H1,
    input  logic [3:0]             cur_H0,
    input  logic [3:0]             cur_M1,
    input  logic [3:0]             cur_M0,
    time_set_ctrl_if.master        ld_bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOAD_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LD_LAST = LW'(LOAD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT_H1,
        S_EDIT_H0,
        S_EDIT_M1,
        S_EDIT_M0,
        S_COMMIT
    } state_t;

    logic mode_ev;
    logic next_ev;
    logic inc_ev;

    time_set_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk(clk), .reset_n(reset_n), .btn(btn_mode), .press(mode_ev)
    );
    time_set_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clk(clk), .reset_n(reset_n), .btn(btn_next), .press(next_ev)
    );
    time_set_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk(clk), .reset_n(reset_n), .btn(btn_inc), .press(inc_ev)
    );

    state_t        state_q, state_d;
    logic          target_q, target_d;
    logic [1:0]    h1_q, h1_d;
    logic [3:0]    h0_q, h0_d;
    logic [3:0]    m1_q, m1_d;
    logic [3:0]    m0_q, m0_d;
    logic [LW-1:0] ld_cnt_q, ld_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ld_time_q, ld_time_d;
    logic          ld_alarm_q, ld_alarm_d;
    logic          editing_q, editing_d;
    logic [1:0]    edit_digit_q, edit_digit_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            target_q     <= 1'b0;
            h1_q         <= '0;
            h0_q         <= '0;
            m1_q         <= '0;
            m0_q         <= '0;
            ld_cnt_q     <= '0;
            to_cnt_q     <= '0;
            ld_time_q    <= 1'b0;
            ld_alarm_q   <= 1'b0;
            editing_q    <= 1'b0;
            edit_digit_q <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            h1_q         <= h1_d;
            h0_q         <= h0_d;
            m1_q         <= m1_d;
            m0_q         <= m0_d;
            ld_cnt_q     <= ld_cnt_d;
            to_cnt_q     <= to_cnt_d;
            ld_time_q    <= ld_time_d;
            ld_alarm_q   <= ld_alarm_d;
            editing_q    <= editing_d;
            edit_digit_q <= edit_digit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        h1_d     = h1_q;
        h0_d     = h0_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        ld_cnt_d = ld_cnt_q;
        to_cnt_d = to_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (mode_ev) begin
                    state_d  = S_EDIT_H1;
                    target_d = sel_alarm;
                    to_cnt_d = '0;
                    if (sel_alarm) begin
                        h1_d = '0;
                        h0_d = '0;
                        m1_d = '0;
                        m0_d = '0;
                    end else begin
                        // Clamp a preload that is not a legal 00:00-23:59 value.
                        h1_d = (cur_H1 > 2'd2) ? 2'd2 : cur_H1;
                        h0_d = (cur_H0 > 4'd9) ? 4'd9 : cur_H0;
                        m1_d = (cur_M1 > 4'd5) ? 4'd5 : cur_M1;
                        m0_d = (cur_M0 > 4'd9) ? 4'd9 : cur_M0;
                        if (h1_d == 2'd2 && h0_d > 4'd3) begin
                            h0_d = 4'd3;
                        end
                    end
                end
            end

            S_EDIT_H1, S_EDIT_H0, S_EDIT_M1, S_EDIT_M0: begin
                if (mode_ev || next_ev || inc_ev) begin
                    to_cnt_d = '0;
                end
                if (mode_ev) begin
                    state_d = S_IDLE;
                end else if (next_ev) begin
                    unique case (state_q)
                        S_EDIT_H1: state_d = S_EDIT_H0;
                        S_EDIT_H0: state_d = S_EDIT_M1;
                        S_EDIT_M1: state_d = S_EDIT_M0;
                        default: begin
                            state_d  = S_COMMIT;
                            ld_cnt_d = '0;
                        end
                    endcase
                end else if (inc_ev) begin
                    unique case (state_q)
                        S_EDIT_H1: begin
                            if (h1_q == 2'd2) begin
                                h1_d = 2'd0;
                            end else begin
                                h1_d = h1_q + 2'd1;
                                if (h1_d == 2'd2 && h0_q > 4'd3) begin
                                    h0_d = 4'd3;
                                end
                            end
                        end
                        S_EDIT_H0: h0_d = (h0_q >= ((h1_q == 2'd2) ? 4'd3 : 4'd9)) ? 4'd0 : h0_q + 4'd1;
                        S_EDIT_M1: m1_d = (m1_q >= 4'd5) ? 4'd0 : m1_q + 4'd1;
                        default:   m0_d = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
                    endcase
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_COMMIT: begin
                // Buttons are ignored here; only the hold counter decides the exit.
                if (ld_cnt_q == LD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        editing_d    = 1'b0;
        edit_digit_d = 2'd0;
        ld_time_d    = 1'b0;
        ld_alarm_d   = 1'b0;
        unique case (state_d)
            S_EDIT_H1: begin editing_d = 1'b1; edit_digit_d = 2'd0; end
            S_EDIT_H0: begin editing_d = 1'b1; edit_digit_d = 2'd1; end
            S_EDIT_M1: begin editing_d = 1'b1; edit_digit_d = 2'd2; end
            S_EDIT_M0: begin editing_d = 1'b1; edit_digit_d = 2'd3; end
            S_COMMIT: begin
                ld_time_d  = ~target_d;
                ld_alarm_d = target_d;
            end
            default: ;
        endcase
    end

    assign ld_bus.H_in1      = h1_q;
    assign ld_bus.H_in0      = h0_q;
    assign ld_bus.M_in1      = m1_q;
    assign ld_bus.M_in0      = m0_q;
    assign ld_bus.LD_time    = ld_time_q;
    assign ld_bus.LD_alarm   = ld_alarm_q;
    assign ld_bus.editing    = editing_q;
    assign ld_bus.edit_digit = edit_digit_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - bench for time_set_ctrl against a digit-level behavioural model
`timescale 1ns/1ps
module tb_time_set_ctrl;
    localparam int DEB   = 2;
    localparam int LOADC = 10;
    localparam int TMO   = 300;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sel_alarm = 1'b0;
    logic [1:0] cur_H1 = '0;
    logic [3:0] cur_H0 = '0;
    logic [3:0] cur_M1 = '0;
    logic [3:0] cur_M0 = '0;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .LOAD_CYCLES(LOADC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_mode(btn_mode),
        .btn_next(btn_next),
        .btn_inc(btn_inc),
        .sel_alarm(sel_alarm),
        .cur_H1(cur_H1),
        .cur_H0(cur_H0),
        .cur_M1(cur_M1),
        .cur_M0(cur_M0),
        .ld_bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: digits as integers, m_pos = -1 idle, 0..3 digit being edited, 4 loading.
    int m_dig[4] = '{0, 0, 0, 0};
    int m_pos = -1;
    bit m_alarm = 1'b0;
    int m_quiet = 0;
    int m_held = 0;
    bit m_d1[3];
    bit m_d2[3];
    int m_hi[3];
    int m_lo[3];
    bit m_locked[3];
    bit m_fire[3];

    task automatic model_reset();
        m_dig = '{0, 0, 0, 0};
        m_pos = -1; m_alarm = 1'b0; m_quiet = 0; m_held = 0;
        for (int b = 0; b < 3; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_hi[b] = 0; m_lo[b] = 0; m_locked[b] = 0; m_fire[b] = 0;
        end
    endtask

    task automatic model_enter();
        m_alarm = sel_alarm;
        if (m_alarm) begin
            m_dig = '{0, 0, 0, 0};
        end else begin
            m_dig[0] = (int'(cur_H1) > 2) ? 2 : int'(cur_H1);
            m_dig[1] = (int'(cur_H0) > 9) ? 9 : int'(cur_H0);
            m_dig[2] = (int'(cur_M1) > 5) ? 5 : int'(cur_M1);
            m_dig[3] = (int'(cur_M0) > 9) ? 9 : int'(cur_M0);
        end
        if (m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 3;
        m_pos = 0;
        m_quiet = 0;
    endtask

    task automatic model_bump();
        int lim;
        lim = (m_pos == 0) ? 2 : (m_pos == 1) ? ((m_dig[0] == 2) ? 3 : 9) : (m_pos == 2) ? 5 : 9;
        m_dig[m_pos] = (m_dig[m_pos] >= lim) ? 0 : m_dig[m_pos] + 1;
        if (m_pos == 0 && m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 3;
    endtask

    task automatic model_step();
        bit ev[3];
        bit raw[3];
        bit s;
        ev  = m_fire;
        raw = '{btn_mode, btn_next, btn_inc};
        if (m_pos < 0) begin
            if (ev[0]) model_enter();
        end else if (m_pos == 4) begin
            m_held++;
            if (m_held == LOADC) m_pos = -1;
        end else begin
            if (ev[0] || ev[1] || ev[2]) m_quiet = 0; else m_quiet++;
            if (ev[0]) m_pos = -1;
            else if (ev[1]) begin m_pos++; m_held = 0; end
            else if (ev[2]) model_bump();
            else if (m_quiet == TMO) m_pos = -1;
        end
        // The debounced level trails the raw pin by two edges; fire once per long-enough high run.
        for (int b = 0; b < 3; b++) begin
            s = m_d2[b];
            if (s) begin m_hi[b]++; m_lo[b] = 0; end
            else begin m_lo[b]++; m_hi[b] = 0; end
            m_fire[b] = 0;
            if (!m_locked[b] && m_hi[b] == DEB) begin m_fire[b] = 1; m_locked[b] = 1; end
            else if (m_locked[b] && m_lo[b] == DEB) m_locked[b] = 0;
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        check("H_in1", bus.H_in1, m_dig[0]);
        check("H_in0", bus.H_in0, m_dig[1]);
        check("M_in1", bus.M_in1, m_dig[2]);
        check("M_in0", bus.M_in0, m_dig[3]);
        check("editing", bus.editing, (m_pos >= 0 && m_pos < 4) ? 1 : 0);
        check("edit_digit", bus.edit_digit, (m_pos >= 0 && m_pos < 4) ? m_pos : 0);
        check("LD_time", bus.LD_time, (m_pos == 4 && !m_alarm) ? 1 : 0);
        check("LD_alarm", bus.LD_alarm, (m_pos == 4 && m_alarm) ? 1 : 0);
    end

    int run_t = 0, run_a = 0, last_t = 0, last_a = 0, pulses_t = 0, pulses_a = 0;
    always @(negedge clk) begin
        if (bus.LD_time) run_t++;
        else if (run_t > 0) begin pulses_t++; last_t = run_t; run_t = 0; end
        if (bus.LD_alarm) run_a++;
        else if (run_a > 0) begin pulses_a++; last_a = run_a; run_a = 0; end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit m, input bit nx, input bit inc, input int hold);
        @(negedge clk);
        btn_mode = m; btn_next = nx; btn_inc = inc;
        repeat (hold) @(negedge clk);
        btn_mode = 0; btn_next = 0; btn_inc = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
        cur_H1 = 2'(h1); cur_H0 = 4'(h0); cur_M1 = 4'(m1); cur_M0 = 4'(m0);
    endtask

    task automatic check_digits(input string name, input int h1, input int h0, input int m1, input int m0);
        check({name, "_h1"}, bus.H_in1, h1);
        check({name, "_h0"}, bus.H_in0, h0);
        check({name, "_m1"}, bus.M_in1, m1);
        check({name, "_m0"}, bus.M_in0, m0);
    endtask

    initial begin
        int seq[5];
        seq = '{1, 2, 3, 0, 1};

        cycles(3);
        check_digits("rst", 0, 0, 0, 0);
        check("rst_ld", {bus.LD_time, bus.LD_alarm, bus.editing, bus.edit_digit}, 0);
        reset_n = 1'b1;
        press(0, 0, 1, 3);
        check_digits("idle_inc", 0, 0, 0, 0);

        // Full time edit from 12:34
        set_cur(1, 2, 3, 4); sel_alarm = 0;
        press(1, 0, 0, 3);
        check("entry_editing", bus.editing, 1);
        check_digits("time_pre", 1, 2, 3, 4);
        repeat (3) press(0, 1, 0, 3);
        check("at_m0", bus.edit_digit, 3);
        press(0, 1, 0, 3);
        check("commit_ldt", bus.LD_time, 1);
        cycles(12);
        check("time_pulses", pulses_t, 1);
        check("time_width", last_t, 10);
        check("time_no_alarm", pulses_a, 0);
        check_digits("time_done", 1, 2, 3, 4);

        // Alarm edit: hour limits, 21:00
        sel_alarm = 1; set_cur(1, 5, 5, 5);
        press(1, 0, 0, 3);
        check_digits("alarm_pre", 0, 0, 0, 0);
        press(0, 0, 1, 3);
        press(0, 0, 1, 3);
        check("h1_two", bus.H_in1, 2);
        press(0, 1, 0, 3);
        for (int i = 0; i < 5; i++) begin
            press(0, 0, 1, 3);
            check("h0_seq", bus.H_in0, seq[i]);
        end
        repeat (3) press(0, 1, 0, 3);
        cycles(12);
        check("alarm_pulses", pulses_a, 1);
        check("alarm_width", last_a, 10);
        check_digits("alarm_done", 2, 1, 0, 0);

        // Clamp and wraps from 17:59
        sel_alarm = 0; set_cur(1, 7, 5, 9);
        press(1, 0, 0, 3);
        press(0, 0, 1, 3);
        check("clamp_h1", bus.H_in1, 2);
        check("clamp_h0", bus.H_in0, 3);
        press(0, 0, 1, 3);
        check("wrap_h1", bus.H_in1, 0);
        check("keep_h0", bus.H_in0, 3);
        press(0, 1, 0, 3); press(0, 1, 0, 3);
        press(0, 0, 1, 3);
        check("wrap_m1", bus.M_in1, 0);
        press(0, 1, 0, 3);
        press(0, 0, 1, 3);
        check("wrap_m0", bus.M_in0, 0);
        press(1, 0, 0, 3);
        check("abort_idle", bus.editing, 0);
        check_digits("abort_keep", 0, 3, 0, 0);
        check("abort_nostrobe", pulses_t, 1);

        // Out-of-range preload 28:00
        set_cur(2, 8, 0, 0);
        press(1, 0, 0, 3);
        check("entry_clamp", bus.H_in0, 3);
        press(1, 0, 0, 3);

        // Glitch, held button, same-cycle priority
        set_cur(1, 0, 0, 0);
        press(1, 0, 0, 3);
        @(negedge clk); btn_inc = 1;
        @(negedge clk); btn_inc = 0;
        cycles(6);
        check("glitch", bus.H_in1, 1);
        press(0, 0, 1, 50);
        check("held_once", bus.H_in1, 2);
        press(0, 1, 0, 3);
        check("at_h0", bus.edit_digit, 1);
        press(1, 1, 0, 3);
        check("prio_abort", bus.editing, 0);
        check("prio_nostrobe", pulses_t + pulses_a, 2);

        // Idle timeout in EDIT_M1
        press(1, 0, 0, 3);
        press(0, 1, 0, 3); press(0, 1, 0, 3);
        check("to_m1", bus.edit_digit, 2);
        cycles(290);
        check("to_before", bus.editing, 1);
        cycles(20);
        check("to_after", bus.editing, 0);
        check("to_nostrobe", pulses_t + pulses_a, 2);

        // Presses during COMMIT are ignored
        sel_alarm = 1;
        press(1, 0, 0, 3);
        repeat (4) press(0, 1, 0, 3);
        press(1, 0, 1, 3);
        cycles(10);
        check("commit_pulses", pulses_a, 2);
        check("commit_width", last_a, 10);
        check("commit_ignored", bus.editing, 0);

        // Reset during COMMIT drops the strobe at once
        press(1, 0, 0, 3);
        repeat (4) press(0, 1, 0, 3);
        check("pre_rst_lda", bus.LD_alarm, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_lda", bus.LD_alarm, 0);
        check("async_edit", bus.editing, 0);
        check_digits("async_rst", 0, 0, 0, 0);
        cycles(3);
        reset_n = 1'b1;
        press(0, 0, 1, 3);
        check_digits("post_rst_inc", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
